// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// mem_arbiter_pkg : shared arbiter states and memory-port dimensions
// Revision 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  localparam int c_addr_w     = 16;
  localparam int c_data_w     = 16;
  localparam int c_fill_words = 8;
  localparam int c_cnt_w      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_FILL = 2'd1,
    D_FILL = 2'd2,
    D_WR   = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_beat_counter.sv
// ============================================================================
// mem_arb_beat_counter : counts read beats of one block fill, flags last beat
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_arb_beat_counter
  import mem_arbiter_pkg::*;
#(
  parameter int FILL_WORDS = c_fill_words,
  parameter int CNT_W      = c_cnt_w
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic done
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(FILL_WORDS - 1);

  logic [CNT_W-1:0] r_count;

  assign done = inc && (r_count == c_last);

  always_ff @(posedge clk) begin
    if (!rst || clr || done) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares the main-memory port between I-cache and D-cache
// Optional macro MEM_ARB_FAIR_EN: round-robin between competing fills.
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = c_addr_w,
  parameter int DATA_W     = c_data_w,
  parameter int FILL_WORDS = c_fill_words,
  parameter int CNT_W      = c_cnt_w
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              i_grant,
  output logic              d_grant,
  output logic              i_data_valid,
  output logic              d_data_valid,
  output logic [DATA_W-1:0] rdata_out
);

  arb_state_t r_state;
  logic       w_beat;
  logic       w_done;
  logic       w_pick_d;
  logic       w_start_d;
  logic       w_start_i;

  // Beats only count while a fill owns the port; stragglers in IDLE are ignored.
  assign w_beat = mem_data_valid && ((r_state == I_FILL) || (r_state == D_FILL));

  mem_arb_beat_counter #(
    .FILL_WORDS (FILL_WORDS),
    .CNT_W      (CNT_W)
  ) u_beat_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (r_state == IDLE),
    .inc  (w_beat),
    .done (w_done)
  );

`ifdef MEM_ARB_FAIR_EN
  logic r_last_d;

  // With both fills pending, the requester that did not own the last fill wins.
  assign w_pick_d = d_mem_read && !(i_mem_read && r_last_d);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_d <= 1'b0;
    end else if (w_start_d) begin
      r_last_d <= 1'b1;
    end else if (w_start_i) begin
      r_last_d <= 1'b0;
    end
  end
`else
  assign w_pick_d = d_mem_read;
`endif

  assign w_start_d = ((r_state == IDLE) && !d_mem_write && w_pick_d)
                   || ((r_state == D_WR) && d_mem_read);
  assign w_start_i = ((r_state == IDLE) && !d_mem_write && !w_pick_d && i_mem_read)
                   || ((r_state == D_WR) && !d_mem_read && i_mem_read);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (d_mem_write)    r_state <= D_WR;
          else if (w_start_d) r_state <= D_FILL;
          else if (w_start_i) r_state <= I_FILL;
        end
        D_WR: begin
          if (w_start_d)      r_state <= D_FILL;
          else if (w_start_i) r_state <= I_FILL;
          else                r_state <= IDLE;
        end
        I_FILL, D_FILL: begin
          if (w_done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Grant is held for the whole fill even if the owner drops its request.
  always_comb begin
    i_grant      = 1'b0;
    d_grant      = 1'b0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    unique case (r_state)
      I_FILL: begin
        i_grant      = 1'b1;
        mem_enable   = i_mem_read;
        mem_addr     = i_mem_addr;
        i_data_valid = mem_data_valid;
      end
      D_FILL: begin
        d_grant      = 1'b1;
        mem_enable   = d_mem_read;
        mem_addr     = d_mem_addr;
        d_data_valid = mem_data_valid;
      end
      D_WR: begin
        d_grant    = 1'b1;
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = d_mem_addr;
        mem_wdata  = d_mem_wdata;
      end
      default: ;
    endcase
  end

  assign rdata_out = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

`ifdef MEM_ARB_FAIR_EN
  localparam bit c_fair = 1'b1;
`else
  localparam bit c_fair = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_mem_read;
  logic [15:0] i_mem_addr;
  logic        d_mem_read;
  logic        d_mem_write;
  logic [15:0] d_mem_addr;
  logic [15:0] d_mem_wdata;
  logic        mem_data_valid;
  logic [15:0] mem_rdata;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        i_grant;
  logic        d_grant;
  logic        i_data_valid;
  logic        d_data_valid;
  logic [15:0] rdata_out;

  int tests    = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_mem_read     (i_mem_read),
    .i_mem_addr     (i_mem_addr),
    .d_mem_read     (d_mem_read),
    .d_mem_write    (d_mem_write),
    .d_mem_addr     (d_mem_addr),
    .d_mem_wdata    (d_mem_wdata),
    .mem_data_valid (mem_data_valid),
    .mem_rdata      (mem_rdata),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .i_grant        (i_grant),
    .d_grant        (d_grant),
    .i_data_valid   (i_data_valid),
    .d_data_valid   (d_data_valid),
    .rdata_out      (rdata_out)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk(tag, {i_grant, d_grant, mem_enable, mem_wr, i_data_valid, d_data_valid,
              mem_addr, mem_wdata}, 64'd0);
  endtask

  task automatic beats(input int n, input bit own_i, input bit drop_last);
    for (int b = 0; b < n; b++) begin
      mem_data_valid = 1'b1;
      mem_rdata      = 16'h1000 + 16'(b);
      if (drop_last && (b == n - 1)) begin
        if (own_i) i_mem_read = 1'b0;
        else       d_mem_read = 1'b0;
      end
      #1;
      chk("beat_grant", {i_grant, d_grant}, own_i ? 2'b10 : 2'b01);
      chk("beat_valid", {i_data_valid, d_data_valid}, own_i ? 2'b10 : 2'b01);
      chk("beat_wr", mem_wr, 1'b0);
      chk("beat_rdata", rdata_out, 16'h1000 + 16'(b));
      tick();
      mem_data_valid = 1'b0;
    end
  endtask

  task automatic sim_fill(input bit first_i);
    i_mem_read = 1'b1; i_mem_addr = 16'h0080;
    d_mem_read = 1'b1; d_mem_addr = 16'h2000;
    chk_idle("both_req_same_cycle");
    tick(); #1;
    chk("both_first_grant", {i_grant, d_grant}, first_i ? 2'b10 : 2'b01);
    chk("both_first_addr", mem_addr, first_i ? 16'h0080 : 16'h2000);
    beats(8, first_i, 1'b1);
    chk_idle("both_gap_idle");
    tick(); #1;
    chk("both_second_grant", {i_grant, d_grant}, first_i ? 2'b01 : 2'b10);
    chk("both_second_addr", mem_addr, first_i ? 16'h2000 : 16'h0080);
    beats(8, !first_i, 1'b1);
    chk_idle("both_done_idle");
  endtask

  initial begin
    rst = 1'b0; i_mem_read = 1'b0; i_mem_addr = '0; d_mem_read = 1'b0;
    d_mem_write = 1'b0; d_mem_addr = '0; d_mem_wdata = '0;
    mem_data_valid = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b1;
    chk_idle("reset_outputs");
    mem_rdata = 16'hA5A5; #1;
    chk("rdata_passthrough", rdata_out, 16'hA5A5);

    // I-only fill, memory latency 4
    i_mem_read = 1'b1; i_mem_addr = 16'h0040; #1;
    chk("ionly_no_same_cycle_grant", {i_grant, mem_enable}, 2'b00);
    tick(); #1;
    chk("ionly_grant", {i_grant, d_grant, mem_enable, mem_wr}, 4'b1010);
    chk("ionly_addr", mem_addr, 16'h0040);
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      chk("ionly_wait_grant", {i_grant, i_data_valid, d_data_valid}, 3'b100);
    end
    beats(8, 1'b1, 1'b1);
    chk_idle("ionly_done_idle");
    mem_data_valid = 1'b1; #1;
    chk("idle_beat_dropped", {i_data_valid, d_data_valid}, 2'b00);
    tick();
    mem_data_valid = 1'b0;

    // Simultaneous fills, last owner I: D first in both builds
    sim_fill(1'b0);

    // Store raised at beat 3 of an I fill waits for the fill to finish
    i_mem_read = 1'b1; i_mem_addr = 16'h0C00;
    tick(); #1;
    chk("store_ifill_grant", i_grant, 1'b1);
    beats(3, 1'b1, 1'b0);
    d_mem_write = 1'b1; d_mem_addr = 16'h3000; d_mem_wdata = 16'h5555; #1;
    chk("store_blocked", {d_grant, mem_wr, mem_wdata}, {2'b00, 16'h0000});
    beats(5, 1'b1, 1'b1);
    chk_idle("store_gap_idle");
    tick(); #1;
    chk("store_dwr_ctl", {d_grant, i_grant, mem_enable, mem_wr}, 4'b1011);
    chk("store_dwr_addr", mem_addr, 16'h3000);
    chk("store_dwr_data", mem_wdata, 16'h5555);
    d_mem_write = 1'b0;
    tick();
    chk_idle("store_after_idle");

    // Write followed by write-miss fill
    d_mem_write = 1'b1; d_mem_read = 1'b1; d_mem_addr = 16'h1234; d_mem_wdata = 16'hBEEF;
    chk_idle("wf_same_cycle");
    tick(); #1;
    chk("wf_dwr_ctl", {d_grant, mem_enable, mem_wr}, 3'b111);
    chk("wf_dwr_addr", mem_addr, 16'h1234);
    chk("wf_dwr_data", mem_wdata, 16'hBEEF);
    d_mem_write = 1'b0;
    tick(); #1;
    chk("wf_fill_ctl", {d_grant, mem_enable, mem_wr}, 3'b110);
    chk("wf_fill_wdata", mem_wdata, 16'h0000);
    beats(8, 1'b0, 1'b1);
    chk_idle("wf_done_idle");

    // Simultaneous fills, last owner D: round-robin favours I
    sim_fill(c_fair);

    // Early request drop keeps the grant through the last beat
    i_mem_read = 1'b1; i_mem_addr = 16'h0100;
    tick();
    beats(4, 1'b1, 1'b0);
    i_mem_read = 1'b0; #1;
    chk("drop_grant_held", {i_grant, mem_enable}, 2'b10);
    beats(4, 1'b1, 1'b0);
    chk_idle("drop_done_idle");

    // Reset at beat 5 aborts the fill; later beats are not forwarded
    i_mem_read = 1'b1; i_mem_addr = 16'h0200;
    tick();
    beats(4, 1'b1, 1'b0);
    mem_data_valid = 1'b1; rst = 1'b0; #1;
    chk("rst_beat5_fwd", i_data_valid, 1'b1);
    tick();
    rst = 1'b1; i_mem_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_idle("rst_late_beat");
      tick();
    end
    mem_data_valid = 1'b0;
    i_mem_read = 1'b1;
    tick();
    beats(8, 1'b1, 1'b1);
    chk_idle("rst_refill_idle");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

`default_nettype wire
